seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Scan controller for the common-anode 7-segment bank. It sequences the digit anodes one at a time, paced by the 480 Hz multiplex strobe, with a blanking guard between digits to prevent ghosting. It selects the nibble and decimal point for the active digit and feeds them to the external segment decoder. New display values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8); data width is 4*NUM_DIGITS
- BLANK_CYCLES, 16, clk_in cycles with all anodes off before each digit is driven (>=1)

Ports (reset reset, asynchronous, active-high; clock clk_in):
- clk_in  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-clk_in-cycle strobe at the multiplex rate (480 Hz)
- load_valid  in  1  new display value offered
- load_data  in  4*NUM_DIGITS  digit nibbles; digit i = bits [4i+3:4i]
- load_dp  in  NUM_DIGITS  decimal-point enables, one per digit
- load_ready  out  1  high when the pending buffer is empty
- digit_en  in  NUM_DIGITS  per-digit enable, sampled live
- lz_suppress  in  1  leading-zero suppression enable, sampled live
- anode  out  NUM_DIGITS  active-low anode drive
- nibble  out  4  nibble of the current digit, to the decoder
- dp_n  out  1  active-low decimal point for the current digit
- scan_idx  out  clog2(NUM_DIGITS)  index of the current digit
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Storage:
  - active register (data + dp): drives the outputs.
  - pending buffer (data + dp + full flag).
- Handshake:
  - load_ready = ~pending_full.
  - On load_valid & load_ready, capture load_data/load_dp into pending and set full.
  - While full, load_valid is ignored and the data is not captured.
- FSM with two states, BLANK and DRIVE, plus a blank counter.
- BLANK:
  - anode all ones.
  - Counter runs from 0 up to BLANK_CYCLES-1, then the FSM enters DRIVE. BLANK_CYCLES=1 means one blank cycle.
  - tick is ignored in BLANK.
- DRIVE:
  - anode[scan_idx] = 0 unless the digit is dark; all other anodes = 1.
  - The FSM stays in DRIVE until tick=1. On that cycle it enters BLANK, and scan_idx advances: scan_idx+1, or 0 when scan_idx = NUM_DIGITS-1.
- Wrap (scan_idx NUM_DIGITS-1 -> 0):
  - frame_done pulses for that one cycle.
  - If pending is full: pending copies to active and full clears in the same edge. load_ready rises the next cycle.
- Dark digit: the digit is dark if digit_en[scan_idx]=0, or if it is leading-zero suppressed.
  - Suppressed means: lz_suppress=1, scan_idx>=1, and every active nibble from NUM_DIGITS-1 down to scan_idx is 0.
  - Digit 0 is never suppressed.
  - A dark digit still consumes its full slot, which keeps brightness uniform.
- Outputs, registered, valid the same cycle as the state and index:
  - nibble = active[4*scan_idx+3 : 4*scan_idx]
  - dp_n = ~active_dp[scan_idx], forced to 1 when the digit is dark or in BLANK.

## Timing
- Reset values:
  - state BLANK, blank counter 0, scan_idx 0
  - anode all ones, nibble 0, dp_n 1, frame_done 0
  - active register 0, pending empty, so load_ready=1 during and after reset
- After reset release: BLANK for BLANK_CYCLES cycles, then digit 0 is driven.
- Tick on cycle T in DRIVE: on T+1, anode = all ones and scan_idx is already updated.
- Digit on-time is the number of cycles from DRIVE entry to the tick. A tick arriving during BLANK is lost, and that digit waits for the next tick.
- Load during a frame: it is never visible before the next wrap. First display of the new value is digit 0 after the wrap's BLANK.
- Load presented on the same edge as a wrap with pending empty:
  - It is captured into pending, not active.
  - It is applied at the following wrap.
- Asserting reset mid-frame immediately forces all anodes off and discards pending data.

## Test plan
- Reset: hold reset with load_valid=1 -> anode=0xFF, dp_n=1, load_ready=1, scan_idx=0, frame_done=0. After release, anode=0xFE exactly 16 cycles later.
- Scan order: tick every 100 cycles, digit_en=0xFF -> anode steps FE, FD, FB ... 7F, back to FE. Each step is preceded by 16 cycles of 0xFF. frame_done pulses once per 8 ticks, on the 7->0 transition.
- Tear-free load: load 0x12345678 mid-frame -> old nibbles shown until the wrap. Then digit0=8, digit7=1. load_ready is low from capture to the cycle after the wrap.
- Back-pressure: second load_valid while pending is full -> not captured. load_ready=0. The first value is applied at the wrap.
- Suppression: active=0x00000A05, lz_suppress=1 -> digits 3..7 dark, digits 0..2 show 5, 0, A. With lz_suppress=0, all 8 digits are lit.
- Digit disable and reset mid-frame:
  - digit_en=0xF0 -> anode stays 0xFF during slots 0..3.
  - Assert reset while in DRIVE of digit 5 -> anode=0xFF immediately, and scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment bank.
// Blank-guarded digit sequencing, frame-aligned display updates, leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          load_valid,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic [NUM_DIGITS-1:0]         load_dp,
  output logic                          load_ready,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          lz_suppress,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [3:0]                    nibble,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);

  // state  | meaning
  // BLANK  | all anodes off for BLANK_CYCLES cycles before the next digit
  // DRIVE  | current digit lit (unless dark) until the next tick
  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_full_q, pend_full_d;

  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [3:0]              nibble_q, nibble_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    all_zero;
  logic                    dark;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRIVE: begin
        if (tick) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  // Capture and frame-boundary transfer are mutually exclusive: capture needs an empty buffer.
  always_comb begin
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (load_valid && !pend_full_q) begin
      pend_data_d = load_data;
      pend_dp_d   = load_dp;
      pend_full_d = 1'b1;
    end
    if (wrap && pend_full_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so they line up with state and index.
  always_comb begin
    all_zero  = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (act_data_d[4*i +: 4] == 4'd0);
      zero_from[i] = all_zero;
    end
    dark = ~digit_en[idx_d] |
           (lz_suppress && (idx_d != '0) && zero_from[idx_d]);

    anode_d      = '1;
    dp_n_d       = 1'b1;
    nibble_d     = act_data_d[{idx_d, 2'b00} +: 4];
    frame_done_d = wrap;
    if (state_d == S_DRIVE && !dark) begin
      anode_d[idx_d] = 1'b0;
      dp_n_d         = ~act_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= S_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      anode_q      <= '1;
      nibble_q     <= 4'd0;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      anode_q      <= anode_d;
      nibble_q     <= nibble_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = ~pend_full_q;
  assign anode      = anode_q;
  assign nibble     = nibble_q;
  assign dp_n       = dp_n_q;
  assign scan_idx   = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (8 digits, 16 blank cycles).
module tb_seg_scan_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        tick;
  logic        load_valid;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic        load_ready;
  logic [7:0]  digit_en;
  logic        lz_suppress;
  logic [7:0]  anode;
  logic [3:0]  nibble;
  logic        dp_n;
  logic [2:0]  scan_idx;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

  seg_scan_ctrl #(.NUM_DIGITS(8), .BLANK_CYCLES(16)) dut (
    .clk_in(clk_in), .reset(reset), .tick(tick),
    .load_valid(load_valid), .load_data(load_data), .load_dp(load_dp),
    .load_ready(load_ready), .digit_en(digit_en), .lz_suppress(lz_suppress),
    .anode(anode), .nibble(nibble), .dp_n(dp_n),
    .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // From a DRIVE slot: dwell, tick once, then check the blank gap and the next digit.
  task automatic tick_and_check(input logic [2:0] e_idx, input logic [7:0] e_anode,
                                input logic [3:0] e_nib, input logic e_dpn,
                                input logic e_fd, input logic e_rdy);
    cyc(4);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("gap_anode", anode, 8'hFF);
    chk("gap_idx", scan_idx, e_idx);
    chk("frame_done", frame_done, e_fd);
    chk("ready_after_tick", load_ready, e_rdy);
    cyc(15);
    chk("gap_end_anode", anode, 8'hFF);
    chk("gap_dp_n", dp_n, 1'b1);
    chk("frame_done_clear", frame_done, 1'b0);
    cyc(1);
    chk("drive_anode", anode, e_anode);
    chk("drive_nibble", nibble, e_nib);
    chk("drive_dp_n", dp_n, e_dpn);
  endtask

  logic [3:0] nib_a05 [8] = '{4'h5, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [7:0] lz_anode [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    reset       = 1'b1;
    tick        = 1'b0;
    load_valid  = 1'b1;
    load_data   = 32'hDEADBEEF;
    load_dp     = 8'hFF;
    digit_en    = 8'hFF;
    lz_suppress = 1'b0;

    // Reset state, with a load offered during reset
    cyc(3);
    chk("rst_anode", anode, 8'hFF);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_idx", scan_idx, 3'd0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_nibble", nibble, 4'h0);
    reset      = 1'b0;
    load_valid = 1'b0;
    cyc(15);
    chk("post_rst_blank", anode, 8'hFF);
    cyc(1);
    chk("post_rst_digit0", anode, 8'hFE);
    chk("post_rst_nibble", nibble, 4'h0);

    // Full scan order with blank data
    for (int i = 1; i <= 8; i++) begin
      logic [2:0] ix;
      ix = 3'(i % 8);
      tick_and_check(ix, ~(8'd1 << ix), 4'h0, 1'b1, ix == 3'd0, 1'b1);
    end

    // Tear-free load mid-frame (now in digit 0)
    load_valid = 1'b1;
    load_data  = 32'h12345678;
    load_dp    = 8'h81;
    cyc(1);
    load_valid = 1'b0;
    chk("load_ready_low", load_ready, 1'b0);
    chk("old_nibble_kept", nibble, 4'h0);
    for (int i = 1; i <= 7; i++)
      tick_and_check(3'(i), ~(8'd1 << i), 4'h0, 1'b1, 1'b0, 1'b0);
    tick_and_check(3'd0, 8'hFE, 4'h8, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++)
      tick_and_check(3'(i), ~(8'd1 << i), 4'(8 - i), (i == 7) ? 1'b0 : 1'b1, 1'b0, 1'b1);

    // Back-pressure: second load while pending is full is dropped
    load_valid = 1'b1;
    load_data  = 32'h00000A05;
    load_dp    = 8'h00;
    cyc(1);
    chk("bp_ready_first", load_ready, 1'b0);
    load_data  = 32'hFFFFFFFF;
    load_dp    = 8'hFF;
    cyc(1);
    load_valid = 1'b0;
    chk("bp_ready_second", load_ready, 1'b0);
    tick_and_check(3'd0, 8'hFE, 4'h5, 1'b1, 1'b1, 1'b1);

    // Leading-zero suppression on 0x00000A05
    lz_suppress = 1'b1;
    for (int i = 1; i <= 7; i++)
      tick_and_check(3'(i), lz_anode[i], nib_a05[i], 1'b1, 1'b0, 1'b1);
    tick_and_check(3'd0, 8'hFE, 4'h5, 1'b1, 1'b1, 1'b1);
    lz_suppress = 1'b0;
    for (int i = 1; i <= 7; i++)
      tick_and_check(3'(i), ~(8'd1 << i), nib_a05[i], 1'b1, 1'b0, 1'b1);

    // Digit disable: slots 0..3 dark
    digit_en = 8'hF0;
    tick_and_check(3'd0, 8'hFF, 4'h5, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++)
      tick_and_check(3'(i), 8'hFF, nib_a05[i], 1'b1, 1'b0, 1'b1);
    tick_and_check(3'd4, 8'hEF, 4'h0, 1'b1, 1'b0, 1'b1);
    tick_and_check(3'd5, 8'hDF, 4'h0, 1'b1, 1'b0, 1'b1);

    // Reset mid-frame in digit 5 with pending data
    load_valid = 1'b1;
    load_data  = 32'h11111111;
    cyc(1);
    load_valid = 1'b0;
    chk("pre_rst_pending", load_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_anode", anode, 8'hFF);
    chk("midrst_idx", scan_idx, 3'd0);
    chk("midrst_ready", load_ready, 1'b1);
    @(negedge clk_in);
    reset    = 1'b0;
    digit_en = 8'hFF;
    cyc(15);
    chk("midrst_blank", anode, 8'hFF);
    cyc(1);
    chk("midrst_digit0", anode, 8'hFE);
    chk("midrst_nibble", nibble, 4'h0);
    chk("midrst_ready_after", load_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
